// File: rtl/hilo_muldiv_ctrl_if.sv
// HI/LO sequencer bus: decode-side op issue, MTHI/MTLO writes, MFHI/MFLO reads and status.
interface hilo_muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_en;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             rd_en;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Decode side.
  modport master (
    output start, op, a, b, mt_en, mt_sel, mt_data, rd_en, rd_sel,
    input  rd_data, stall, busy, done, hi, lo
  );

  // HI/LO owner.
  modport slave (
    input  start, op, a, b, mt_en, mt_sel, mt_data, rd_en, rd_sel,
    output rd_data, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner running iterative multiply/divide, one bit per cycle.
// Operands are reduced to magnitudes at issue and the sign is restored in a final fix-up cycle.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  hilo_muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             b_zero_q, b_zero_d;
  // Mult: acc = product high half, shreg = multiplier shifting out / product low half.
  // Div:  acc = partial remainder, shreg = dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_sign, b_sign;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;

  assign a_sign = bus.op[0] & bus.a[WIDTH-1];
  assign b_sign = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag  = a_sign ? -bus.a : bus.a;
  assign b_mag  = b_sign ? -bus.b : bus.b;

  assign mul_sum   = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_shift = {acc_q, shreg_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opnd_q};
  // Only used when rem_ge, so the difference always fits in WIDTH bits.
  assign rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;

  // Next-state: issue, iterate, sign fix-up, and MTHI/MTLO writes while idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mt_en) begin
          if (bus.mt_sel) lo_d = bus.mt_data;
          else            hi_d = bus.mt_data;
        end
        if (bus.start) begin
          state_d  = StRun;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          a_neg_d  = a_sign;
          b_neg_d  = b_sign;
          b_zero_d = (bus.b == '0);
          acc_d    = '0;
          if (bus.op[1]) begin
            shreg_d = a_mag;
            opnd_d  = b_mag;
          end else begin
            shreg_d = b_mag;
            opnd_d  = a_mag;
          end
        end
      end
      StRun: begin
        if (is_div_q) begin
          // A zero divisor always "fits": quotient becomes all-ones, remainder becomes |a|.
          acc_d   = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
          shreg_d = {shreg_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d   = mul_sum[WIDTH:1];
          shreg_d = {mul_sum[0], shreg_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Remainder carries the dividend sign; with b == 0 this restores a as issued.
          hi_d = a_neg_q ? -acc_q : acc_q;
          if (b_zero_q)               lo_d = '1;
          else if (a_neg_q ^ b_neg_q) lo_d = -shreg_q;
          else                        lo_d = shreg_q;
        end else begin
          {hi_d, lo_d} = (a_neg_q ^ b_neg_q) ? -{acc_q, shreg_q} : {acc_q, shreg_q};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      shreg_q  <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.stall   = (bus.rd_en | bus.mt_en) & bus.busy;
  assign bus.rd_data = bus.rd_sel ? lo_q : hi_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
